// File: rtl/sram_ctrl_if.sv
// Bus between the MEM-stage pipeline, the SRAM controller and the external
// 16-bit SRAM. The controller uses the slave modport; the pipeline side uses master.
interface sram_ctrl_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_ctrl.sv
// Splits each 32-bit pipeline access into two 16-bit SRAM half-accesses
// (low half, then high half), each lasting WAIT_CYCLES clock cycles.
module sram_ctrl #(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
  input logic         clk,
  input logic         rst_n,
  sram_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state_reg, state_next;
  logic [3:0]  cnt_reg;
  logic [31:0] addr_reg;
  logic [31:0] data_reg;
  logic        wr_reg;
  logic [31:0] read_data_reg;

  logic        request;
  logic        in_phase;
  logic        phase_end;
  logic [16:0] word_idx;

  assign request   = bus.wr_en | bus.rd_en;
  assign in_phase  = (state_reg == LOW) || (state_reg == HIGH);
  assign phase_end = in_phase && (cnt_reg == LAST);
  // Address arithmetic wraps modulo 2^32; out-of-range words alias silently.
  assign word_idx  = 17'((addr_reg - ADDR_BASE) >> 2);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (request)   state_next = LOW;
      LOW:     if (phase_end) state_next = HIGH;
      HIGH:    if (phase_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      addr_reg      <= 32'd0;
      data_reg      <= 32'd0;
      wr_reg        <= 1'b0;
      read_data_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= (in_phase && !phase_end) ? cnt_reg + 4'd1 : 4'd0;

      // Simultaneous wr_en and rd_en resolves to a write.
      if (state_reg == IDLE && request) begin
        addr_reg <= bus.address;
        data_reg <= bus.write_data;
        wr_reg   <= bus.wr_en;
      end

      if (!wr_reg && phase_end) begin
        if (state_reg == LOW) read_data_reg[15:0]  <= bus.sram_dq_in;
        else                  read_data_reg[31:16] <= bus.sram_dq_in;
      end
    end
  end

  always_comb begin
    bus.sram_addr   = 18'd0;
    bus.sram_dq_out = 16'd0;
    bus.sram_dq_oe  = 1'b0;
    bus.sram_we_n   = 1'b1;
    if (in_phase) begin
      bus.sram_addr = {word_idx, state_reg == HIGH};
      if (wr_reg) begin
        bus.sram_dq_out = (state_reg == HIGH) ? data_reg[31:16] : data_reg[15:0];
        bus.sram_dq_oe  = 1'b1;
        // Strobe rises on the final cycle so the SRAM commits with data still stable.
        bus.sram_we_n   = phase_end;
      end
    end
  end

  assign bus.read_data = read_data_reg;
  assign bus.ready     = !request || (state_reg == DONE);

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural 16-bit SRAM that commits a
// write on the last cycle of a driven phase (strobe high, bus still driven).
module tb_sram_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [15:0] mem [0:255];

  sram_ctrl_if bus ();

  sram_ctrl #(.WAIT_CYCLES(5), .ADDR_BASE(32'd1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.sram_dq_in = mem[bus.sram_addr[7:0]];

  always @(posedge clk) begin
    if (bus.sram_dq_oe && bus.sram_we_n)
      mem[bus.sram_addr[7:0]] <= bus.sram_dq_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one access from a negedge in IDLE; leaves the bench at the negedge of cycle 12.
  task automatic do_access(input string name, input logic w, input logic r,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [17:0] lo, input logic [31:0] exp_rd);
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin
        bus.wr_en      = w;
        bus.rd_en      = r;
        bus.address    = a;
        bus.write_data = d;
      end
      #1;
      if (c == 0)  chk({name, " ready c0"},  bus.ready, 1'b0);
      if (c == 1)  chk({name, " addr lo"},   bus.sram_addr, lo);
      if (c == 3)  chk({name, " oe"},        bus.sram_dq_oe, w);
      if (c == 4)  chk({name, " we_n c4"},   bus.sram_we_n, !w);
      if (c == 5)  chk({name, " we_n c5"},   bus.sram_we_n, 1'b1);
      if (c == 6)  chk({name, " addr hi"},   bus.sram_addr, lo | 18'd1);
      if (c == 10) chk({name, " ready c10"}, bus.ready, 1'b0);
      if (c == 10) chk({name, " we_n c10"},  bus.sram_we_n, 1'b1);
      if (c == 11) chk({name, " ready c11"}, bus.ready, 1'b1);
      if (c == 11) chk({name, " addr done"}, bus.sram_addr, 18'd0);
      if (c == 11) chk({name, " read_data"}, bus.read_data, exp_rd);
      // Scramble inputs after the latch edge; the access must not notice.
      if (c == 1) begin
        bus.address    = 32'd0;
        bus.write_data = ~d;
      end
      if (c == 11) begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
      end
      @(negedge clk);
    end
    $display("access %s wr=%0b rd=%0b addr=%0d data=%h read_data=%h", name, w, r, a, d, bus.read_data);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst_n          = 1'b0;
    bus.wr_en      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.address    = 32'd0;
    bus.write_data = 32'd0;

    @(negedge clk);
    #1;
    chk("reset ready", bus.ready, 1'b1);
    chk("reset we_n", bus.sram_we_n, 1'b1);
    chk("reset oe", bus.sram_dq_oe, 1'b0);
    chk("reset read_data", bus.read_data, 32'd0);
    chk("reset addr", bus.sram_addr, 18'd0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (5) @(negedge clk);
    #1;
    chk("idle ready", bus.ready, 1'b1);
    chk("idle we_n", bus.sram_we_n, 1'b1);
    chk("idle oe", bus.sram_dq_oe, 1'b0);
    @(negedge clk);

    do_access("wr1024", 1'b1, 1'b0, 32'd1024, 32'h1234_5678, 18'd0, 32'd0);
    chk("mem0", mem[0], 32'h5678);
    chk("mem1", mem[1], 32'h1234);

    do_access("rd1024", 1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 32'h1234_5678);
    do_access("wr1032", 1'b1, 1'b0, 32'd1032, 32'h0BAD_BEEF, 18'd4, 32'h1234_5678);

    do_access("wr1035", 1'b1, 1'b0, 32'd1035, 32'hCAFE_F00D, 18'd4, 32'h1234_5678);
    chk("mem4", mem[4], 32'hF00D);
    chk("mem5", mem[5], 32'hCAFE);

    do_access("wrrd1028", 1'b1, 1'b1, 32'd1028, 32'hAAAA_5555, 18'd2, 32'h1234_5678);
    chk("mem2", mem[2], 32'h5555);
    chk("mem3", mem[3], 32'hAAAA);

    // Abandon a write in cycle 7: low half is committed, high half is not.
    bus.wr_en      = 1'b1;
    bus.address    = 32'd1024;
    bus.write_data = 32'hDEAD_BEEF;
    repeat (7) @(negedge clk);
    rst_n     = 1'b0;
    bus.wr_en = 1'b0;
    #1;
    chk("abort ready", bus.ready, 1'b1);
    chk("abort we_n", bus.sram_we_n, 1'b1);
    chk("abort oe", bus.sram_dq_oe, 1'b0);
    chk("abort addr", bus.sram_addr, 18'd0);
    chk("abort dq_out", bus.sram_dq_out, 16'd0);
    chk("abort read_data", bus.read_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort mem0", mem[0], 32'hBEEF);
    chk("abort mem1", mem[1], 32'h1234);
    $display("abort reset read_data=%h mem0=%h mem1=%h", bus.read_data, mem[0], mem[1]);
    @(negedge clk);

    do_access("rd_after_rst", 1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 32'h1234_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 5: cycles per 16-bit SRAM half-access; legal range 2..15.
REQ-002 Parameter ADDR_BASE, default 1024: byte address mapped to SRAM word 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 wr_en  input  1  memory write request from the MEM stage.
REQ-006 rd_en  input  1  memory read request from the MEM stage.
REQ-007 address  input  32  byte address (ALU result).
REQ-008 write_data  input  32  store data (Val_Rm).
REQ-009 read_data  output  32  registered load data.
REQ-010 ready  output  1  low while an access is incomplete; the pipeline freezes on low.
REQ-011 sram_addr  output  18  SRAM half-word address.
REQ-012 sram_dq_out  output  16  SRAM write data.
REQ-013 sram_dq_oe  output  1  high means the controller drives the SRAM data bus.
REQ-014 sram_dq_in  input  16  SRAM read data.
REQ-015 sram_we_n  output  1  SRAM write strobe, active-low.

Function
REQ-016 FSM states: IDLE, LOW, HIGH, DONE; one phase counter of 4 bits.
REQ-017 IDLE to LOW: on a clock edge with wr_en or rd_en high. At that edge, latch address, write_data and op (write if wr_en, otherwise read).
REQ-018 wr_en and rd_en both high: the access is treated as a write.
REQ-019 LOW and HIGH each last exactly WAIT_CYCLES cycles. The counter clears on phase entry, and the phase ends when the counter equals WAIT_CYCLES-1.
REQ-020 LOW to HIGH to DONE to IDLE. DONE lasts exactly one cycle.
REQ-021 Word index = (latched address - ADDR_BASE) >> 2, computed modulo 2^32. Bits [1:0] are ignored. Out-of-range addresses wrap with no error.
REQ-022 sram_addr = {word[16:0], 0} in LOW and {word[16:0], 1} in HIGH. sram_addr = 0 in IDLE and DONE.
REQ-023 Write, LOW phase: sram_dq_out = data[15:0].
REQ-024 Write, HIGH phase: sram_dq_out = data[31:16].
REQ-025 Write, both phases: sram_dq_oe = 1 for the whole phase. sram_we_n = 0 except on the last cycle of each phase, where it is 1.
REQ-026 Read: sram_dq_oe = 0 and sram_we_n = 1 throughout. On the last cycle of LOW, capture sram_dq_in into read_data[15:0]; on the last cycle of HIGH, capture it into read_data[31:16].
REQ-027 read_data is unchanged by writes and holds its value until the next read completes.
REQ-028 ready = !(wr_en | rd_en) | (state == DONE), combinational.
REQ-029 Latency: call the request's first IDLE cycle cycle 0. ready is low in cycles 0..2*WAIT_CYCLES and high in cycle 2*WAIT_CYCLES+1. With defaults, ready is high in cycle 11.
REQ-030 A request that deasserts mid-access does not abort it. The access completes on its latched values.
REQ-031 Requests still high in DONE are ignored. The next access can start only from IDLE, the cycle after DONE.
REQ-032 Input changes after the latch edge do not affect the access in progress.

Reset
REQ-033 While rst_n = 0, regardless of the clock: state = IDLE, counter = 0, read_data = 0, sram_addr = 0, sram_dq_out = 0, sram_dq_oe = 0, sram_we_n = 1.
REQ-034 Reset during an access abandons it. A partially written word is left as-is.
REQ-035 After rst_n rises, the first edge with a request starts a fresh access.

Verification
REQ-036 No request after reset -> ready = 1, sram_we_n = 1, sram_dq_oe = 0 indefinitely.
REQ-037 Write 0x12345678 to address 1024 -> SRAM[0] = 0x5678 and SRAM[1] = 0x1234; ready low in cycles 0..10 and high in cycle 11; sram_we_n = 1 in cycles 5 and 10.
REQ-038 Read address 1024 after REQ-037 -> read_data = 0x12345678 in cycle 11, held through a following write to 1032.
REQ-039 Write 0xCAFEF00D to address 1035 -> halves go to sram_addr 4 and 5; bits [1:0] are ignored.
REQ-040 wr_en = rd_en = 1 with write_data 0xAAAA5555 at address 1028 -> write occurs (SRAM[2] = 0x5555, SRAM[3] = 0xAAAA); read_data is unchanged.
REQ-041 rst_n pulsed low in cycle 7 of a write -> outputs match REQ-033 immediately and SRAM[1] is not written; a new read then completes normally with 11-cycle latency.
